// File: rtl/cart_rom_fetch.sv
// cart_rom_fetch: strobe-driven SDRAM ROM byte fetch with wait stall, out-of-image FF, timeout abort; optional one-entry cache via CART_FETCH_CACHE_EN
module cart_rom_fetch #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [24:0] rom_size,
  input  logic [24:0] mem_addr,
  input  logic        cs,
  input  logic        rd,
  output logic [7:0]  data,
  output logic        wait_n,
  output logic [24:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic [7:0]  sdram_dout
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state;
  logic prev;
  logic [7:0] cnt;
  logic act, start, in_range, hit;
  logic [7:0] hit_data;
  assign act = cs & rd;
  assign start = act & ~prev;
  assign in_range = mem_addr < rom_size;
  assign wait_n = !((start & in_range & !hit) | (state == REQ));
`ifdef CART_FETCH_CACHE_EN
  logic c_valid;
  logic [24:0] c_tag;
  logic [7:0] c_data;
  logic [24:0] size_q;
  assign hit = c_valid & (c_tag == mem_addr);
  assign hit_data = c_data;
  always_ff @(posedge clk)
    if (reset) begin
      c_valid <= 1'b0;
      c_tag <= '0;
      c_data <= 8'hFF;
      size_q <= '0;
    end else begin
      if (state == REQ && sdram_ack) begin
        c_valid <= 1'b1;
        c_tag <= sdram_addr;
        c_data <= sdram_dout;
      end
      if (rom_size != size_q) c_valid <= 1'b0;
      size_q <= rom_size;
    end
`else
  assign hit = 1'b0;
  assign hit_data = 8'hFF;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      data <= 8'hFF;
      sdram_req <= 1'b0;
      sdram_addr <= '0;
      prev <= 1'b0;
      cnt <= '0;
    end else begin
      prev <= act;
      case (state)
        IDLE:
          if (start) begin
            if (!in_range) begin
              data <= 8'hFF;
              state <= DONE;
            end else if (hit) begin
              data <= hit_data;
              state <= DONE;
            end else begin
              sdram_addr <= mem_addr;
              sdram_req <= 1'b1;
              cnt <= '0;
              state <= REQ;
            end
          end
        REQ:
          if (sdram_ack) begin
            data <= sdram_dout;
            sdram_req <= 1'b0;
            state <= DONE;
          end else if (cnt == 8'(TIMEOUT)) begin
            data <= 8'hFF;
            sdram_req <= 1'b0;
            state <= DONE;
          end else cnt <= cnt + 8'd1;
        default:
          if (!act) state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cart_rom_fetch.sv
// tb_cart_rom_fetch: directed bench with a cycle-window reference model checked every cycle
module tb_cart_rom_fetch;
  localparam int TO = 4;
  logic clk = 1'b0, reset = 1'b0, cs = 1'b0, rd = 1'b0, sdram_ack = 1'b0;
  logic [24:0] rom_size = 25'd32768, mem_addr = '0;
  logic [7:0] sdram_dout = '0;
  logic [7:0] data;
  logic wait_n, sdram_req;
  logic [24:0] sdram_addr;
  int checks = 0, errors = 0;
  bit armed = 0;
  int wl_cnt = 0, rq_cnt = 0, rise_cnt = 0;
  logic req_d = 1'b0;

  cart_rom_fetch #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .rom_size(rom_size), .mem_addr(mem_addr),
    .cs(cs), .rd(rd), .data(data), .wait_n(wait_n), .sdram_addr(sdram_addr),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_dout(sdram_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: a fetch occupies the window of cycles [win_lo, win_lo+TO] or ends early on ack.
  int cyc = 0, win_lo = 0;
  bit busy = 0, hold = 0, m_prev = 0;
  logic [7:0] m_data = 8'hFF;
  logic [24:0] m_addr = '0;
  bit c_v = 0;
  logic [24:0] c_tag = '0, size_last = '0;
  logic [7:0] c_byte = '0;
  logic m_hit, raw_start, m_range;
`ifdef CART_FETCH_CACHE_EN
  assign m_hit = c_v && (c_tag == mem_addr);
`else
  assign m_hit = 1'b0;
`endif
  assign raw_start = cs && rd && !m_prev;
  assign m_range = mem_addr < rom_size;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      busy <= 0;
      hold <= 0;
      m_prev <= 0;
      m_data <= 8'hFF;
      m_addr <= '0;
      c_v <= 0;
      size_last <= '0;
    end else begin
      m_prev <= cs && rd;
      if (busy) begin
        if (sdram_ack) begin
          m_data <= sdram_dout;
          busy <= 0;
          hold <= 1;
          c_v <= 1;
          c_tag <= m_addr;
          c_byte <= sdram_dout;
        end else if (cyc == win_lo + TO) begin
          m_data <= 8'hFF;
          busy <= 0;
          hold <= 1;
        end
      end else if (hold) begin
        if (!(cs && rd)) hold <= 0;
      end else if (raw_start) begin
        hold <= !m_range || m_hit;
        busy <= m_range && !m_hit;
        if (!m_range) m_data <= 8'hFF;
        else if (m_hit) m_data <= c_byte;
        else begin
          m_addr <= mem_addr;
          win_lo <= cyc + 1;
        end
      end
      if (rom_size != size_last) c_v <= 0;
      size_last <= rom_size;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("data", 32'(data), 32'(m_data));
      chk("sdram_req", 32'(sdram_req), 32'(busy));
      chk("wait_n", 32'(wait_n), 32'(!(busy || (raw_start && m_range && !m_hit))));
      if (busy) chk("sdram_addr", 32'(sdram_addr), 32'(m_addr));
    end
    if (!wait_n) wl_cnt++;
    if (sdram_req) rq_cnt++;
    if (sdram_req && !req_d) rise_cnt++;
    req_d = sdram_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic strobe(input logic [24:0] a);
    mem_addr = a;
    cs = 1'b1;
    rd = 1'b1;
  endtask
  task automatic drop();
    cs = 1'b0;
    rd = 1'b0;
    tick();
    tick();
  endtask
  task automatic ack(input logic [7:0] d);
    sdram_ack = 1'b1;
    sdram_dout = d;
    tick();
    sdram_ack = 1'b0;
  endtask

  int w0, r0, s0;
  task automatic snap();
    w0 = wl_cnt;
    r0 = rq_cnt;
    s0 = rise_cnt;
  endtask

  initial begin
    reset = 1'b1;
    tick();
    armed = 1;
    tick();
    chk("rst_data", 32'(data), 32'hFF);
    chk("rst_req", 32'(sdram_req), 32'h0);
    chk("rst_addr", 32'(sdram_addr), 32'h0);
    reset = 1'b0;
    tick();
    snap();
    strobe(25'h4000);
    repeat (3) tick();
    ack(8'hA5);
    chk("s1_data", 32'(data), 32'hA5);
    chk("s1_wait", 32'(wait_n), 32'h1);
    chk("s1_wait_low", 32'(wl_cnt - w0), 32'd4);
    chk("s1_req_cyc", 32'(rq_cnt - r0), 32'd3);
    chk("s1_req_rise", 32'(rise_cnt - s0), 32'd1);
    drop();
    snap();
    strobe(25'h8000);
    tick();
    chk("oor_data", 32'(data), 32'hFF);
    drop();
    chk("oor_wait_low", 32'(wl_cnt - w0), 32'd0);
    chk("oor_req", 32'(rq_cnt - r0), 32'd0);
    strobe(25'h7FFF);
    tick();
    ack(8'hC3);
    chk("early_data", 32'(data), 32'hC3);
    drop();
    snap();
    strobe(25'h0010);
    repeat (6) tick();
    chk("to_data", 32'(data), 32'hFF);
    chk("to_wait", 32'(wait_n), 32'h1);
    chk("to_req_cyc", 32'(rq_cnt - r0), 32'd5);
    drop();
    strobe(25'h0020);
    repeat (5) tick();
    ack(8'hE7);
    chk("ack_vs_to", 32'(data), 32'hE7);
    drop();
    snap();
    strobe(25'h0123);
    tick();
    tick();
    cs = 1'b0;
    rd = 1'b0;
    tick();
    tick();
    ack(8'h3C);
    chk("drop_data", 32'(data), 32'h3C);
    chk("drop_addr", 32'(sdram_addr), 32'h0123);
    tick();
    tick();
    chk("drop_one_req", 32'(rise_cnt - s0), 32'd1);
    strobe(25'h0200);
    tick();
    tick();
    reset = 1'b1;
    cs = 1'b0;
    rd = 1'b0;
    tick();
    reset = 1'b0;
    chk("mid_rst_req", 32'(sdram_req), 32'h0);
    ack(8'h77);
    chk("mid_rst_data", 32'(data), 32'hFF);
    chk("mid_rst_wait", 32'(wait_n), 32'h1);
    tick();
    rom_size = '0;
    tick();
    snap();
    strobe(25'h0);
    tick();
    drop();
    chk("nocart_wait_low", 32'(wl_cnt - w0), 32'd0);
    chk("nocart_req", 32'(rq_cnt - r0), 32'd0);
    rom_size = 25'd32768;
    tick();
`ifdef CART_FETCH_CACHE_EN
    strobe(25'h0123);
    tick();
    tick();
    ack(8'h5A);
    drop();
    snap();
    strobe(25'h0123);
    chk("hit_wait", 32'(wait_n), 32'h1);
    tick();
    chk("hit_data", 32'(data), 32'h5A);
    drop();
    chk("hit_no_req", 32'(rq_cnt - r0), 32'd0);
    rom_size = 25'd32767;
    tick();
    snap();
    strobe(25'h0123);
    tick();
    tick();
    ack(8'h66);
    chk("inval_data", 32'(data), 32'h66);
    chk("inval_req", 32'(rise_cnt - s0), 32'd1);
    drop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
